// File: rtl/cfg_types_pkg.sv
// Shared types for the accelerator and its APB control block: accelerator
// state/error enums, control FSM states and the register map layout.
package cfg_types_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } acc_state_t;

    typedef enum logic [1:0] {
        ER_NONE        = 2'd0,
        ER_INVALID_CFG = 2'd1
    } acc_error_t;

    typedef enum logic [1:0] {
        CS_IDLE   = 2'd0,
        CS_LAUNCH = 2'd1,
        CS_RUN    = 2'd2
    } acc_ctrl_state_t;

    // Word offsets, decoded from paddr[3:2]
    localparam logic [1:0] ACC_REG_CTRL   = 2'd0;
    localparam logic [1:0] ACC_REG_STATUS = 2'd1;
    localparam logic [1:0] ACC_REG_CFG    = 2'd2;
    localparam logic [1:0] ACC_REG_CYCLES = 2'd3;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_RUNNING_BIT = 1;
    localparam int STATUS_ACC_ERR_BIT = 2;
    localparam int STATUS_DONE_BIT    = 3;
    localparam int STATUS_CFG_ERR_BIT = 4;

    // The address counter walks word pairs, so a run needs a nonzero even count
    function automatic logic cfg_is_valid(input logic [7:0] count);
        return (count != 8'd0) && !count[0];
    endfunction

endpackage

// File: rtl/acc_cycle_counter.sv
// 32-bit run-length counter: synchronous clear, count enable, saturates at all ones.
module acc_cycle_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (clr) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/acc_ctrl_regs.sv
// APB register block that configures, launches and monitors the address-counter
// accelerator. Optional level interrupt enabled by defining ACC_CTRL_IRQ_EN.
module acc_ctrl_regs
    import cfg_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  start,
    output logic [7:0]            max_cnt,
    output logic [7:0]            incr,
    input  logic                  done,
    input  acc_state_t            accel_state,
    input  acc_error_t            accel_error,
    output logic                  irq
);

    acc_ctrl_state_t state, next_state;
    logic [15:0] cfg_reg;
    logic        done_flag;
    logic        cfg_err_flag;
    logic        irq_en;
    logic [31:0] cycles;

    logic [1:0] reg_sel;
    logic       wr_access, busy, start_req, cfg_wr, status_wr, ctrl_wr_ok;
    logic       launch, bad_start, done_set;
    logic       unused_bits;

    assign reg_sel    = paddr[3:2];
    assign wr_access  = psel & penable & pwrite;
    assign busy       = (state != CS_IDLE);
    assign start_req  = wr_access && (reg_sel == ACC_REG_CTRL) && pwdata[CTRL_START_BIT];
    assign cfg_wr     = wr_access && (reg_sel == ACC_REG_CFG);
    assign status_wr  = wr_access && (reg_sel == ACC_REG_STATUS);
    assign ctrl_wr_ok = wr_access && (reg_sel == ACC_REG_CTRL) && !(busy && pwdata[CTRL_START_BIT]);
    assign launch     = start_req && !busy && cfg_is_valid(cfg_reg[7:0]);
    assign bad_start  = start_req && !busy && !cfg_is_valid(cfg_reg[7:0]);
    assign done_set   = (state == CS_RUN) && done;

    assign pready  = 1'b1;
    assign pslverr = busy && (cfg_wr || start_req);
    assign start   = (state == CS_LAUNCH);
    assign max_cnt = cfg_reg[7:0];
    assign incr    = cfg_reg[15:8];

    assign unused_bits = ^{paddr[ADDR_WIDTH-1:4], paddr[1:0], pwdata[DATA_WIDTH-1:16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CS_IDLE:   if (launch) next_state = CS_LAUNCH;
            CS_LAUNCH: next_state = CS_RUN;
            CS_RUN:    if (done) next_state = CS_IDLE;
            default:   next_state = CS_IDLE;
        endcase
    end

    // Sticky flags: a hardware set in the same cycle as a W1C wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_reg      <= 16'd0;
            done_flag    <= 1'b0;
            cfg_err_flag <= 1'b0;
        end else begin
            if (cfg_wr && !busy) begin
                cfg_reg <= pwdata[15:0];
            end
            if (done_set) begin
                done_flag <= 1'b1;
            end else if (status_wr && pwdata[STATUS_DONE_BIT]) begin
                done_flag <= 1'b0;
            end
            if (bad_start) begin
                cfg_err_flag <= 1'b1;
            end else if (status_wr && pwdata[STATUS_CFG_ERR_BIT]) begin
                cfg_err_flag <= 1'b0;
            end
        end
    end

`ifdef ACC_CTRL_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr_ok) begin
                irq_en <= pwdata[CTRL_IRQ_EN_BIT];
            end
            irq <= done_flag & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
    logic unused_ctrl;
    assign unused_ctrl = ctrl_wr_ok;
`endif

    acc_cycle_counter u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .en    ((state == CS_LAUNCH) || (state == CS_RUN)),
        .count (cycles)
    );

    always_comb begin
        prdata = '0;
        if (psel) begin
            case (reg_sel)
                ACC_REG_CTRL: begin
                    prdata[CTRL_IRQ_EN_BIT] = irq_en;
                end
                ACC_REG_STATUS: begin
                    prdata[STATUS_BUSY_BIT]    = busy;
                    prdata[STATUS_RUNNING_BIT] = (accel_state == ST_RUNNING);
                    prdata[STATUS_ACC_ERR_BIT] = (accel_error == ER_INVALID_CFG);
                    prdata[STATUS_DONE_BIT]    = done_flag;
                    prdata[STATUS_CFG_ERR_BIT] = cfg_err_flag;
                end
                ACC_REG_CFG: begin
                    prdata[15:0] = cfg_reg;
                end
                default: begin
                    prdata[31:0] = cycles;
                end
            endcase
        end
    end

endmodule

// File: doc/acc_ctrl_regs.md
# acc_ctrl_regs

APB slave register block sitting directly upstream of the accelerator address-counter FSM. It holds the run configuration (`max_cnt`, `incr`) stable during a run and launches each run with a single-cycle `start` pulse. It watches `done`, `accel_state` and `accel_error`, latches a sticky completion flag and a run-length cycle count, and optionally raises a level interrupt. Software programs and polls the accelerator only through this block.

## Interface
- `ADDR_WIDTH`, default 12: APB address width; only `paddr[3:2]` is decoded.
- `DATA_WIDTH`, default 32: APB data width; fixed at 32.
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `psel`, `penable`, `pwrite`, in, 1 each: APB control.
- `paddr`, in, ADDR_WIDTH: byte address.
- `pwdata`, in, DATA_WIDTH: write data.
- `prdata`, out, DATA_WIDTH: read data.
- `pready`, out, 1: APB ready; constant 1.
- `pslverr`, out, 1: APB error.
- `start`, out, 1: run launch pulse to the accelerator.
- `max_cnt`, out, 8: word count for the run.
- `incr`, out, 8: byte increment for the run.
- `done`, in, 1: accelerator last-write indication.
- `accel_state`, in, `acc_state_t`: accelerator state.
- `accel_error`, in, `acc_error_t`: accelerator configuration error.
- `irq`, out, 1: level interrupt.

## Operation
- Register map, by `paddr[3:2]`:
  - 0 CTRL: bit0 START, write-1 launches a run and always reads 0. Bit1 IRQ_EN.
  - 1 STATUS: bit0 BUSY (internal state ≠ IDLE). Bit1 RUNNING (`accel_state==ST_RUNNING`). Bit2 ACC_ERR (`accel_error==ER_INVALID_CFG`). Bit3 DONE, sticky, W1C. Bit4 CFG_ERR, sticky, W1C. Read-only bits ignore writes.
  - 2 CFG: [7:0] `max_cnt`, [15:8] `incr`, other bits read 0.
  - 3 CYCLES: 32-bit read-only run length.
- Address bits above [3:2] are ignored; the four registers alias.
- Access rules:
  - A write is accepted only on `psel & penable & pwrite`.
  - `pslverr` is 1 on a CFG write while BUSY; the write is ignored.
  - `pslverr` is 1 on a START write while BUSY; the write is ignored, no relaunch.
- Control FSM `acc_ctrl_state_t`:
  - IDLE -> LAUNCH: START written and config valid.
  - LAUNCH -> RUN: unconditional.
  - RUN -> IDLE: on `done==1`.
- Config validity: `max_cnt` nonzero and even. A START with invalid config sets CFG_ERR, no launch, `pslverr=0`.
- `start` is 1 exactly in LAUNCH.
- `max_cnt` and `incr` are driven from the CFG register, which is frozen while BUSY.
- Cycle counter:
  - Cleared to 0 on IDLE->LAUNCH.
  - Increments in LAUNCH and in RUN, including the `done` cycle.
  - Saturates at 0xFFFF_FFFF.
  - Holds its value in IDLE.
  - For a well-behaved accelerator, CYCLES = `max_cnt`+1.
- DONE is set on RUN & `done`.
- `done` outside RUN is ignored.
- Simultaneous W1C and set of DONE or CFG_ERR in the same cycle: the set wins.

## Timing
- APB has zero wait states; `prdata` is combinational from registers during the access phase, and is 0 when not selected.
- `start` rises on the clock edge after the accepted START write and is high for exactly 1 cycle.
- DONE, CYCLES and the IDLE return all update on the edge that samples `done=1`.
- `irq` follows one cycle after DONE is set.
- Reset values: `prdata`=0, `pready`=1, `pslverr`=0, `start`=0, `max_cnt`=0, `incr`=0, `irq`=0, CYCLES=0, all sticky bits 0, state IDLE.
- Reset mid-run: the block returns to IDLE immediately with all registers at reset values. The accelerator must share this reset domain.

## Configuration
- Macro `ACC_CTRL_IRQ_EN`.
- Defined: CTRL.IRQ_EN is a read/write bit with reset 0, and `irq` = DONE & IRQ_EN (registered).
- Undefined: IRQ_EN reads 0 and ignores writes, and `irq` is tied to 0. The port stays present so instantiation is unchanged.

## Structure
- `cfg_types_pkg` gains:
  - register word-offset localparams `ACC_REG_CTRL`, `ACC_REG_STATUS`, `ACC_REG_CFG`, `ACC_REG_CYCLES`;
  - STATUS/CTRL bit-index localparams;
  - enum `acc_ctrl_state_t {CS_IDLE, CS_LAUNCH, CS_RUN}`.
- `acc_state_t` and `acc_error_t` are reused from the same package.
- One sub-module: `acc_cycle_counter`, a 32-bit saturating counter with `clr` and `en` inputs.

## Test plan
- Reset → all outputs at the reset values above. Read STATUS → 0x0; read CFG → 0x0.
- Write CFG=0x0304, then START → `start` high 1 cycle, `max_cnt`=4, `incr`=3. Accelerator model asserts `done` 4 cycles after `start` → STATUS.DONE=1, CYCLES=5, BUSY=0.
- Write CFG `max_cnt`=5, then START → no `start` pulse, CFG_ERR=1, `pslverr`=0. Write 0x10 to STATUS → CFG_ERR=0.
- During RUN: write CFG=0x0102 → `pslverr`=1 and CFG unchanged. Write START → `pslverr`=1 and no second `start` pulse.
- W1C of DONE in the same cycle `done` arrives → DONE stays 1. With `ACC_CTRL_IRQ_EN` and IRQ_EN=1 → `irq`=1 until DONE is cleared. Without the macro → `irq` always 0.
- Assert `rst` mid-RUN → immediate return to IDLE with CYCLES=0 and `start`=0. A subsequent valid START runs normally.
